// File: rtl/mtimer_pkg.sv
// Shared register map and reset constants for the mtimer machine-timer peripheral.
// Used by mtimer, the bus decoder and the firmware header generator.
package mtimer_pkg;

    localparam logic [2:0] MTIMER_OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIMER_OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMER_OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMER_OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] MTIMER_OFF_PRESCALE    = 3'd4;

    // All-ones compare value keeps the interrupt quiet out of reset.
    localparam logic [63:0] MTIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic is_mtime_off(input logic [2:0] off);
        return (off == MTIMER_OFF_MTIME_LO) || (off == MTIMER_OFF_MTIME_HI);
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick divider for mtimer: issues one tick every divisor+1 cycles.
// Only instantiated when MTIMER_PRESCALER_EN is defined.
module mtimer_prescaler (
    input  logic       clk,
    input  logic       resetb,
    input  logic       reload,
    input  logic [7:0] divisor,
    output logic       tick
);

    logic [7:0] r_count;

    assign tick = (r_count == divisor);

    // NOTE: resetb is synchronous, so it is tested inside the clocked branch, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_count <= 8'd0;
        end else if (reload || tick) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime, mtimecmp, registered level irq_mtimecmp.
// Optional tick prescaler enabled by defining MTIMER_PRESCALER_EN.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [63:0] CMP_RESET = MTIMER_CMP_RESET
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_mtimecmp
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_hi_shadow;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic        w_wr;
    logic        w_rd;
    logic        w_wr_mtime;
    logic        w_tick;
    logic [7:0]  w_prescale;
    logic [63:0] w_mtime_next;
    logic [31:0] w_rd_mux;

    assign w_wr       = sel && we;
    assign w_rd       = sel && !we;
    assign w_wr_mtime = w_wr && is_mtime_off(addr);

`ifdef MTIMER_PRESCALER_EN
    logic [7:0] r_prescale;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_prescale <= 8'd0;
        end else if (w_wr && addr == MTIMER_OFF_PRESCALE) begin
            r_prescale <= wdata[7:0];
        end
    end

    assign w_prescale = r_prescale;

    mtimer_prescaler u_prescaler (
        .clk     (clk),
        .resetb  (resetb),
        .reload  (w_wr_mtime || (w_wr && addr == MTIMER_OFF_PRESCALE)),
        .divisor (r_prescale),
        .tick    (w_tick)
    );
`else
    assign w_prescale = 8'd0;
    assign w_tick     = 1'b1;
`endif

    // A bus write to either mtime half wins over the tick; the other half holds (no carry).
    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_mtime_next = r_mtime;
        if (w_wr && addr == MTIMER_OFF_MTIME_LO) begin
            w_mtime_next[31:0] = wdata;
        end else if (w_wr && addr == MTIMER_OFF_MTIME_HI) begin
            w_mtime_next[63:32] = wdata;
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (addr)
            MTIMER_OFF_MTIME_LO:    w_rd_mux = r_mtime[31:0];
            MTIMER_OFF_MTIME_HI:    w_rd_mux = r_hi_shadow;
            MTIMER_OFF_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
            MTIMER_OFF_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
            MTIMER_OFF_PRESCALE:    w_rd_mux = {24'd0, w_prescale};
            default:                w_rd_mux = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_mtime     <= 64'd0;
            r_mtimecmp  <= CMP_RESET;
            r_hi_shadow <= 32'd0;
            r_rdata     <= 32'd0;
            r_irq       <= 1'b0;
        end else begin
            r_mtime <= w_mtime_next;
            r_irq   <= (r_mtime >= r_mtimecmp);
            if (w_wr && addr == MTIMER_OFF_MTIMECMP_LO) begin
                r_mtimecmp[31:0] <= wdata;
            end
            if (w_wr && addr == MTIMER_OFF_MTIMECMP_HI) begin
                r_mtimecmp[63:32] <= wdata;
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
                if (addr == MTIMER_OFF_MTIME_LO) begin
                    r_hi_shadow <= r_mtime[63:32];
                end
            end
        end
    end

    assign rdata        = r_rdata;
    assign irq_mtimecmp = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer; expected values are hand-computed.
// Covers both builds via MTIMER_PRESCALER_EN.
module tb_mtimer;
    import mtimer_pkg::*;

    logic        clk = 1'b0;
    logic        resetb;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq_mtimecmp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;

    mtimer dut (
        .clk          (clk),
        .resetb       (resetb),
        .sel          (sel),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .irq_mtimecmp (irq_mtimecmp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a negedge and consume exactly one clock.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        d = rdata;
        sel = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
        @(negedge clk);
        idle(3);
        check("reset_rdata", rdata, 0);
        check("reset_irq", irq_mtimecmp, 0);

        // Free-run: mtime = 10 at the read's sampling edge.
        resetb = 1'b1;
        idle(10);
        bus_read(MTIMER_OFF_MTIME_LO, rd);
        check("freerun_lo", rd, 32'd10);
        check("freerun_irq", irq_mtimecmp, 0);

        // Snapshot and carry across the 32-bit boundary.
        bus_write(MTIMER_OFF_MTIME_LO, 32'hFFFF_FFFE);
        bus_write(MTIMER_OFF_MTIME_HI, 32'h0);
        idle(1);
        bus_read(MTIMER_OFF_MTIME_LO, rd);
        check("snap_lo", rd, 32'hFFFF_FFFF);
        idle(3);
        bus_read(MTIMER_OFF_MTIME_HI, rd);
        check("snap_hi_shadow", rd, 32'h0);
        bus_read(MTIMER_OFF_MTIME_LO, rd);
        check("carry_lo", rd, 32'h4);
        bus_read(MTIMER_OFF_MTIME_HI, rd);
        check("carry_hi", rd, 32'h1);

        // Interrupt: mtimecmp = 100, mtime = 95.
        bus_write(MTIMER_OFF_MTIME_HI, 32'h0);
        bus_write(MTIMER_OFF_MTIME_LO, 32'd95);
        bus_write(MTIMER_OFF_MTIMECMP_LO, 32'd100);
        bus_write(MTIMER_OFF_MTIMECMP_HI, 32'h0);
        check("irq_m97", irq_mtimecmp, 0);
        idle(1); check("irq_m98", irq_mtimecmp, 0);
        idle(1); check("irq_m99", irq_mtimecmp, 0);
        idle(1); check("irq_m100", irq_mtimecmp, 0);
        idle(1); check("irq_m101", irq_mtimecmp, 1);
        bus_write(MTIMER_OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
        check("irq_hold_after_cmpwr", irq_mtimecmp, 1);
        idle(1); check("irq_fall", irq_mtimecmp, 0);

        // Write vs tick: 6 edges from write to read sample.
        bus_write(MTIMER_OFF_MTIME_LO, 32'h1234);
        idle(5);
        bus_read(MTIMER_OFF_MTIME_LO, rd);
        check("wr_vs_tick_lo", rd, 32'h1239);
        bus_read(MTIMER_OFF_MTIME_HI, rd);
        check("wr_vs_tick_hi", rd, 32'h0);

        // Prescaler (or its absence in the default build).
        bus_write(MTIMER_OFF_PRESCALE, 32'd3);
        bus_write(MTIMER_OFF_MTIME_LO, 32'd0);
        idle(12);
        bus_read(MTIMER_OFF_MTIME_LO, rd);
`ifdef MTIMER_PRESCALER_EN
        check("presc_lo", rd, 32'd3);
        bus_read(MTIMER_OFF_PRESCALE, rd);
        check("presc_reg", rd, 32'd3);
`else
        check("presc_lo", rd, 32'd12);
        bus_read(MTIMER_OFF_PRESCALE, rd);
        check("presc_reg", rd, 32'd0);
`endif

        // Reserved offset: reads 0, writes change nothing.
        bus_write(3'd6, 32'hDEAD_BEEF);
        bus_read(3'd6, rd);
        check("rsvd_read", rd, 32'h0);
        bus_read(MTIMER_OFF_MTIMECMP_LO, rd);
        check("rsvd_cmplo", rd, 32'd100);
        bus_read(MTIMER_OFF_MTIMECMP_HI, rd);
        check("rsvd_cmphi", rd, 32'hFFFF_FFFF);

        // Reset during a read (rdata currently nonzero).
        sel = 1'b1; we = 1'b0; addr = MTIMER_OFF_MTIMECMP_HI; resetb = 1'b0;
        @(negedge clk);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_irq", irq_mtimecmp, 0);
        resetb = 1'b1;
        bus_read(MTIMER_OFF_MTIME_LO, rd);
        check("midrst_mtime", rd, 32'h0);
        bus_read(MTIMER_OFF_MTIMECMP_LO, rd);
        check("midrst_cmplo", rd, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register, and the level timer-interrupt line `irq_mtimecmp`. `irq_mtimecmp` is the input of the CSR/exception unit, which gates it with `mie.MTIE`, edge-detects it and raises cause 0x80000007. The block sits on the data-memory bus as a word-addressed peripheral and is upstream of the CSR/EHU.

## Interface
Parameters:
- `CMP_RESET`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`, so no interrupt after reset.

Ports:
- `clk` input 1: clock.
- `resetb` input 1: reset, synchronous, active-low.
- `sel` input 1: bus access to this block this cycle.
- `we` input 1: 1 = write, 0 = read; valid with `sel`.
- `addr` input 3: word offset `addr[4:2]`.
  - 0 = MTIME_LO, 1 = MTIME_HI, 2 = MTIMECMP_LO, 3 = MTIMECMP_HI, 4 = PRESCALE.
  - 5–7 are reserved.
- `wdata` input 32: write data. Writes are full-word only.
- `rdata` output 32: read data, registered.
- `irq_mtimecmp` output 1: level interrupt, registered.

## Operation
- **Reset**
  - `mtime` = 0, `mtimecmp` = `CMP_RESET`, `hi_shadow` = 0.
  - Prescaler count = 0, PRESCALE = 0.
  - `rdata` = 0, `irq_mtimecmp` = 0.
- **Tick.** `mtime` increments by 1 (64-bit, wraps from all-ones to 0) on every tick.
  - A tick is every cycle, or a prescaler tick when the prescaler is compiled in (see Configuration).
- **Writes**
  - A write to MTIME_LO replaces `mtime[31:0]`. A write to MTIME_HI replaces `mtime[63:32]`.
  - In a write cycle to MTIME_* the increment is suppressed for the whole 64-bit counter. The written value holds exactly, and the unwritten half keeps its old value (no carry).
  - A write to MTIMECMP_LO or MTIMECMP_HI replaces that half only.
  - Writes to reserved offsets are ignored.
- **Atomic 64-bit reads**
  - A read of MTIME_LO returns `mtime[31:0]` and, in the same edge, captures `mtime[63:32]` into `hi_shadow`.
  - A read of MTIME_HI returns `hi_shadow`, not the live value. Software reads LO then HI.
  - A HI read without a preceding LO read returns the last captured value.
- **Other reads**
  - MTIMECMP_* return the register.
  - PRESCALE returns `{24'b0, prescale}`.
  - Reserved offsets return 0.
  - When `sel` = 0, `rdata` holds its previous value.
- **Compare.** `irq_mtimecmp` <= (`mtime` >= `mtimecmp`), using an unsigned 64-bit compare of the current-cycle register values, registered.
- **Clearing the interrupt.** Software clears it by writing `mtimecmp` above `mtime`.
  - Writing HI = 0xFFFF_FFFF first, then LO, then HI avoids a spurious match. This is software's responsibility, not checked by hardware.

## Timing
- **Read latency 1.** With `sel`=1 and `we`=0 sampled at edge k, `rdata` is valid after edge k. No wait states; `sel` may assert every cycle.
- **Write latency.**
  - A write sampled at edge k is visible to a read sampled at edge k+1.
  - `mtime` resumes incrementing from the written value at edge k+1.
- **Interrupt latency.** If `mtime` reaches `mtimecmp` after edge k, `irq_mtimecmp` rises after edge k+1. Deassertion has the same latency after a compare write.
- **Simultaneous events.**
  - A bus write to MTIME_* beats the tick.
  - A LO read in the same cycle as a tick captures the pre-increment HI and returns the pre-increment LO, so the pair is consistent.
- **Reset mid-operation.** Synchronous reset overrides any in-flight access. `rdata` and `irq_mtimecmp` are 0 after the reset edge.

## Configuration
- Macro `MTIMER_PRESCALER_EN`.
- **Defined:**
  - PRESCALE is an 8-bit register (reset 0).
  - An internal 8-bit counter counts up each cycle. When count == PRESCALE it issues a tick and reloads to 0, so `mtime` advances once every PRESCALE+1 cycles.
  - A write to PRESCALE also clears the counter.
  - A write to MTIME_* clears the counter.
- **Undefined:**
  - A tick occurs every cycle.
  - PRESCALE reads 0, writes are ignored, and no counter flops exist.

## Structure
- Package `mtimer_pkg`: register offset constants (`MTIMER_OFF_MTIME_LO` … `MTIMER_OFF_PRESCALE`) and `CMP_RESET` default. Shared with the bus decoder and the firmware header generator.
- Sub-module `mtimer_prescaler` (clk, resetb, `reload`, `divisor[7:0]`, `tick`). Instantiated only under `MTIMER_PRESCALER_EN`; otherwise `tick` is tied to 1.

## Test plan
- **Reset and free-run.** Release reset, idle 10 cycles, read LO -> 32'd10 (±1 for read latency, exact value fixed by bench), `irq_mtimecmp`=0.
- **Snapshot and carry.** Write LO=0xFFFF_FFFE and HI=0. Read LO -> 0xFFFF_FFFF (read cycle 1 after writes). Idle 3 cycles, then read HI -> 0, because the shadow was captured at the LO read. Read LO again, then HI -> 1.
- **Interrupt.**
  - Set `mtimecmp`=100 and `mtime`=95: `irq_mtimecmp` rises exactly on the cycle `mtime`=101 is first observable (1 cycle after the match).
  - Then write CMPHI=0xFFFF_FFFF: `irq_mtimecmp` falls 2 edges after the write.
- **Write vs tick.** Write MTIME_LO=0x1234 while ticking: the next LO read returns 0x1234 + (cycles elapsed − 1), with no lost or double increment.
- **Prescaler (`MTIMER_PRESCALER_EN`).**
  - PRESCALE=3, `mtime`=0: after 12 cycles LO = 3.
  - Undefined build: PRESCALE reads 0 and `mtime` advances every cycle.
- **Reserved offset and reset mid-read.**
  - Read offset 6 -> 0; a write to offset 6 has no effect on any register.
  - Assert `resetb`=0 during a read: `rdata`=0 and `mtime`=0 next cycle.
